// File: rtl/reservation_station_pkg.sv
// Shared types, sizes and opcode classes for the integer reservation station.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE       = 8;
  localparam int unsigned RS_SIZE_WIDTH = 3;
  localparam int unsigned ROB_WIDTH     = 3;
  localparam int unsigned XLEN          = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

  typedef struct packed {
    logic                 busy;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [6:0]           itype;
    logic [2:0]           op;
    logic                 f7b;
    logic [XLEN-1:0]      vj;
    logic [ROB_WIDTH-1:0] qj;
    logic                 j_ready;
    logic [XLEN-1:0]      vk;
    logic [ROB_WIDTH-1:0] qk;
    logic                 k_ready;
  } rs_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [XLEN-1:0]      value;
  } cdb_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] value;
  } snoop_t;

  // Match a pending tag against both CDB sources; the LSB value wins a double hit.
  function automatic snoop_t cdb_pick(input logic [ROB_WIDTH-1:0] tag,
                                      input cdb_t own, input cdb_t lsb);
    snoop_t s;
    s = '0;
    if (own.valid && own.rob_id == tag) begin
      s.hit   = 1'b1;
      s.value = own.value;
    end
    if (lsb.valid && lsb.rob_id == tag) begin
      s.hit   = 1'b1;
      s.value = lsb.value;
    end
    return s;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, LSB broadcast and result bus of the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic                 issue_valid;
  logic [6:0]           issue_type;
  logic [2:0]           issue_op;
  logic                 issue_f7b;
  logic [ROB_WIDTH-1:0] issue_rob_id;
  logic [XLEN-1:0]      issue_vj;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic                 issue_j_ready;
  logic [XLEN-1:0]      issue_vk;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic                 issue_k_ready;
  logic [XLEN-1:0]      issue_imm;
  logic                 rs_full;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_rob_id;
  logic [XLEN-1:0]      lsb_value;
  logic                 rs_ready;
  logic [ROB_WIDTH-1:0] rs_rob_id;
  logic [XLEN-1:0]      rs_value;

  modport slave (
    input  issue_valid, issue_type, issue_op, issue_f7b, issue_rob_id,
           issue_vj, issue_qj, issue_j_ready, issue_vk, issue_qk, issue_k_ready,
           issue_imm, lsb_ready, lsb_rob_id, lsb_value,
    output rs_full, rs_ready, rs_rob_id, rs_value
  );

  modport master (
    output issue_valid, issue_type, issue_op, issue_f7b, issue_rob_id,
           issue_vj, issue_qj, issue_j_ready, issue_vk, issue_qk, issue_k_ready,
           issue_imm, lsb_ready, lsb_rob_id, lsb_value,
    input  rs_full, rs_ready, rs_rob_id, rs_value
  );

endinterface

// File: rtl/reservation_station_alu.sv
// Combinational integer ALU and branch comparator, shared by execution units.
module rs_alu
  import reservation_station_pkg::*;
(
  input  logic [6:0]      type_i,
  input  logic [2:0]      op_i,
  input  logic            f7b_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  logic       arith;

  assign shamt = b_i[4:0];
  // Immediate shifts carry the sra select in imm[10].
  assign arith = (type_i == I_TYPE) ? b_i[10] : f7b_i;

  // Branch outcome or ALU result.
  always_comb begin
    result_o = '0;
    if (type_i == B_TYPE) begin
      case (op_i)
        3'b000:  result_o = XLEN'(a_i == b_i);
        3'b001:  result_o = XLEN'(a_i != b_i);
        3'b100:  result_o = XLEN'($signed(a_i) < $signed(b_i));
        3'b101:  result_o = XLEN'($signed(a_i) >= $signed(b_i));
        3'b110:  result_o = XLEN'(a_i < b_i);
        3'b111:  result_o = XLEN'(a_i >= b_i);
        default: result_o = '0;
      endcase
    end else begin
      case (op_i)
        3'b000:  result_o = (type_i == R_TYPE && f7b_i) ? a_i - b_i : a_i + b_i;
        3'b001:  result_o = a_i << shamt;
        3'b010:  result_o = XLEN'($signed(a_i) < $signed(b_i));
        3'b011:  result_o = XLEN'(a_i < b_i);
        3'b100:  result_o = a_i ^ b_i;
        3'b101:  result_o = arith ? XLEN'($signed(a_i) >>> shamt) : a_i >> shamt;
        3'b110:  result_o = a_i | b_i;
        default: result_o = a_i & b_i;
      endcase
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Integer reservation station: holds ALU/branch ops until operands arrive, dispatches one per cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  reservation_station_if.slave  bus
);

  rs_entry_t                ent_q [RS_SIZE];
  rs_entry_t                ent_d [RS_SIZE];
  cdb_t                     res_q, res_d;
  cdb_t                     lsb_cdb;
  snoop_t                   j_snp [RS_SIZE];
  snoop_t                   k_snp [RS_SIZE];
  snoop_t                   iss_j, iss_k;
  rs_entry_t                issue_e;
  logic                     free_found, disp_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx, disp_idx;
  logic [XLEN-1:0]          alu_result;

  assign lsb_cdb = '{valid: bus.lsb_ready, rob_id: bus.lsb_rob_id, value: bus.lsb_value};

  assign bus.rs_full   = ~free_found;
  assign bus.rs_ready  = res_q.valid;
  assign bus.rs_rob_id = res_q.rob_id;
  assign bus.rs_value  = res_q.value;

  // Lowest-index free slot and lowest-index ready entry, from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = RS_SIZE_WIDTH'(i);
      end
      if (ent_q[i].busy && ent_q[i].j_ready && ent_q[i].k_ready) begin
        disp_found = 1'b1;
        disp_idx   = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // CDB tag matches for stored entries and for the operands being issued.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      j_snp[i] = cdb_pick(ent_q[i].qj, res_q, lsb_cdb);
      k_snp[i] = cdb_pick(ent_q[i].qk, res_q, lsb_cdb);
    end
    iss_j = cdb_pick(bus.issue_qj, res_q, lsb_cdb);
    iss_k = cdb_pick(bus.issue_qk, res_q, lsb_cdb);
  end

  // Build the incoming entry, taking operands from the CDB when they are broadcast now.
  always_comb begin
    issue_e        = '0;
    issue_e.busy   = 1'b1;
    issue_e.rob_id = bus.issue_rob_id;
    issue_e.itype  = bus.issue_type;
    issue_e.op     = bus.issue_op;
    issue_e.f7b    = bus.issue_f7b;
    issue_e.qj     = bus.issue_qj;
    issue_e.qk     = bus.issue_qk;
    if (bus.issue_j_ready) begin
      issue_e.vj      = bus.issue_vj;
      issue_e.j_ready = 1'b1;
    end else if (iss_j.hit) begin
      issue_e.vj      = iss_j.value;
      issue_e.j_ready = 1'b1;
    end
    if (bus.issue_type == I_TYPE) begin
      issue_e.vk      = bus.issue_imm;
      issue_e.k_ready = 1'b1;
    end else if (bus.issue_k_ready) begin
      issue_e.vk      = bus.issue_vk;
      issue_e.k_ready = 1'b1;
    end else if (iss_k.hit) begin
      issue_e.vk      = iss_k.value;
      issue_e.k_ready = 1'b1;
    end
  end

  rs_alu u_alu (
    .type_i   (ent_q[disp_idx].itype),
    .op_i     (ent_q[disp_idx].op),
    .f7b_i    (ent_q[disp_idx].f7b),
    .a_i      (ent_q[disp_idx].vj),
    .b_i      (ent_q[disp_idx].vk),
    .result_o (alu_result)
  );

  // Next state: flush, or wakeup + dispatch + issue.
  always_comb begin
    ent_d       = ent_q;
    res_d       = res_q;
    res_d.valid = 1'b0;
    if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy && !ent_q[i].j_ready && j_snp[i].hit) begin
          ent_d[i].vj      = j_snp[i].value;
          ent_d[i].j_ready = 1'b1;
        end
        if (ent_q[i].busy && !ent_q[i].k_ready && k_snp[i].hit) begin
          ent_d[i].vk      = k_snp[i].value;
          ent_d[i].k_ready = 1'b1;
        end
      end
      if (disp_found) begin
        ent_d[disp_idx].busy = 1'b0;
        res_d.valid          = 1'b1;
        res_d.rob_id         = ent_q[disp_idx].rob_id;
        res_d.value          = alu_result;
      end
      if (bus.issue_valid && free_found) ent_d[free_idx] = issue_e;
    end
  end

  // State register: synchronous reset, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      res_q <= '0;
    end else if (rdy) begin
      ent_q <= ent_d;
      res_q <= res_d;
    end
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Integer reservation station between the Decoder/issue stage and the RoB.
- Holds issued ALU and branch instructions until both source operands are available.
- Snoops the common data bus (its own result bus and the LSB result bus) to capture operands.
- Executes one ready entry per cycle and broadcasts the result to the RoB on rs_ready / rs_rob_id / rs_value.

Parameters:
- RS_SIZE, 8, number of entries.
- RS_SIZE_WIDTH, 3, log2(RS_SIZE).
- ROB_WIDTH, 3, RoB tag width; equals `ROB_SIZE_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rdy  in  1  global enable; state frozen when low.
- clear  in  1  misprediction flush from RoB.
- issue_valid  in  1  new instruction this cycle.
- issue_type  in  7  opcode class: `R_TYPE, `I_TYPE or `B_TYPE.
- issue_op  in  3  funct3.
- issue_f7b  in  1  instr[30] (sub/sra select).
- issue_rob_id  in  ROB_WIDTH  destination RoB tag.
- issue_vj  in  32  rs1 value (valid if issue_j_ready).
- issue_qj  in  ROB_WIDTH  rs1 producer tag.
- issue_j_ready  in  1  rs1 value valid.
- issue_vk  in  32  rs2 value (valid if issue_k_ready).
- issue_qk  in  ROB_WIDTH  rs2 producer tag.
- issue_k_ready  in  1  rs2 value valid.
- issue_imm  in  32  immediate.
- rs_full  out  1  no free entry (combinational).
- lsb_ready  in  1  LSB broadcast valid.
- lsb_rob_id  in  ROB_WIDTH  LSB broadcast tag.
- lsb_value  in  32  LSB broadcast value.
- rs_ready  out  1  result broadcast valid (registered).
- rs_rob_id  out  ROB_WIDTH  result tag (registered).
- rs_value  out  32  result (registered).

Behaviour:
- Reset and enable:
  - Synchronous active-high rst clears every busy bit and drives rs_ready=0, rs_rob_id=0, rs_value=0 at the next posedge, independent of rdy.
  - rdy=0: no state change and outputs hold. Re-sampling a held broadcast is idempotent for consumers.
  - clear&&rdy: all busy cleared and rs_ready=0 at the edge. An issue_valid in the same cycle is dropped.
- Issue:
  - Issue is legal only when rs_full=0. issue_valid while full is ignored (bench flags it as a protocol error).
  - The lowest-index free entry is written.
  - `I_TYPE: operand k = issue_imm, marked ready; issue_vk/qk/k_ready are ignored.
- Wakeup:
  - CDB sources: {rs_ready, rs_rob_id, rs_value} (own registered output) and {lsb_ready, lsb_rob_id, lsb_value}.
  - Every busy entry with a pending tag equal to a valid CDB tag captures the value at the edge.
  - Issue bypass: if an issuing operand's tag matches a valid CDB broadcast in the same cycle, that value is captured at issue and the operand is marked ready.
  - If both CDB tags match (illegal per RoB uniqueness), the LSB value wins.
- Dispatch:
  - Each cycle, select the lowest-index entry that is busy with both operands ready. Readiness is registered state only; wakeup does not dispatch in the same cycle.
  - At the edge: the entry is freed, rs_ready=1, rs_rob_id = entry tag, rs_value = ALU result.
  - With no candidate, rs_ready=0 at the edge.
  - Latency: operands ready in state at cycle N → result visible in cycle N+1. A dependent entry captures it at the N+1 edge and dispatches at the earliest at the N+2 edge.
- Free-slot timing: an entry freed by dispatch is usable by issue from the next cycle. rs_full is computed from current busy bits only. Issue and dispatch of different entries in the same cycle are legal.
- ALU, all arithmetic mod 2^32, shift amount = k[4:0]:
  - funct3 000: add; sub if `R_TYPE && f7b.
  - 001: sll.
  - 010: slt (signed).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra if f7b. For `I_TYPE, f7b = imm[10].
  - 110: or.
  - 111: and.
- Branch (`B_TYPE): value = 32'd1 if taken, else 32'd0.
  - funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - Undefined funct3 yields 0.

Decomposition:
- Shared config.v: `R_TYPE/`I_TYPE/`B_TYPE opcode macros, `ROB_SIZE_WIDTH, and new `RS_SIZE/`RS_SIZE_WIDTH.
- Sub-module rs_alu: purely combinational; inputs type, op, f7b, a, b; output 32-bit result. Reused by later execution units.

Test Plan:
- Reset then issue add (vj=5, vk=7, both ready, rob 2) → next cycle rs_ready=1, rs_rob_id=2, rs_value=12; the cycle after, rs_ready=0.
- Issue sub rob 1 (qj=3 pending, vk=4); LSB broadcasts tag 3, value 10 → one cycle after capture, rs_value=6, rs_rob_id=1.
- Issue addi rob 0 (1+1), then dependent add rob 1 on tag 0 with vk=3 → rob 1 result 5 broadcast exactly 2 cycles after rob 0's result.
- Fill 8 entries all waiting on tag 7 → rs_full=1. LSB broadcasts tag 7 → entries drain in index order, one per cycle. rs_full drops the cycle after the first dispatch.
- Branches: blt (-1, 1) → 1; bltu (0xFFFFFFFF, 1) → 0; bge (3, 3) → 1; srai of 0x80000000 by 4 → 0xF8000000.
- Assert clear with 3 pending entries, plus issue_valid in the same cycle → rs_full=0, no further rs_ready. rst mid-operation → outputs 0 at the next edge.
